// File: rtl/cmp_pkg.sv
// Shared types and constants for the comparator operand issue stage.
package cmp_pkg;

    localparam int CMP_WIDTH = 32;
    localparam logic [CMP_WIDTH-1:0] SIGN_BIAS = {1'b1, {(CMP_WIDTH-1){1'b0}}};

    typedef struct packed {
        logic [CMP_WIDTH-1:0] a;
        logic [CMP_WIDTH-1:0] b;
    } cmp_pair_t;

endpackage

// File: rtl/cmp_fifo2.sv
// Generic 2-entry FIFO: push visible at head next cycle, count decoded by caller.
// Never accepts a push at count 2; flush empties it and wins over push/pop.
module cmp_fifo2
    import cmp_pkg::*;
#(
    parameter type T = cmp_pair_t
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       flush,
    input  logic       push,
    input  logic       pop,
    input  T           wdata,
    output T           rdata,
    output logic [1:0] count
);

    T     mem [2];
    logic wptr;
    logic rptr;

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            count <= 2'd0;
            wptr  <= 1'b0;
            rptr  <= 1'b0;
        end else begin
            if (push) wptr <= ~wptr;
            if (pop)  rptr <= ~rptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; contents are only observed while count is nonzero.
    always_ff @(posedge clock) begin
        if (push) mem[wptr] <= wdata;
    end

    assign rdata = mem[rptr];

endmodule

// File: rtl/cmp_issue.sv
// Operand issue stage for the gt comparator: sign-biases pairs, buffers two, 1-cycle latency.
// in_ready depends only on registered occupancy; out_* hold while out_ready is low.
module cmp_issue
    import cmp_pkg::*;
#(
    parameter int WIDTH = CMP_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [31:0]      issue_count
);

    localparam logic [WIDTH-1:0] BIAS = {1'b1, {(WIDTH-1){1'b0}}};

    logic       push;
    logic       pop;
    logic [1:0] count;
    cmp_pair_t  wpair;
    cmp_pair_t  head;
    logic [31:0] issue_cnt;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    // Flipping the MSB maps signed order onto unsigned order for gt.
    assign wpair.a = in_signed ? (in_a ^ BIAS) : in_a;
    assign wpair.b = in_signed ? (in_b ^ BIAS) : in_b;

    cmp_fifo2 #(.T(cmp_pair_t)) u_fifo (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .wdata (wpair),
        .rdata (head),
        .count (count)
    );

    assign out_a = out_valid ? head.a : '0;
    assign out_b = out_valid ? head.b : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            issue_cnt <= 32'd0;
        end else if (pop) begin
            issue_cnt <= issue_cnt + 32'd1;
        end
    end

    assign issue_count = issue_cnt;

endmodule

// File: tb/tb_cmp_issue.sv
// Directed bench for cmp_issue: bias, backpressure, streaming, flush, reset, counter wrap.
module tb_cmp_issue;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_signed;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [31:0] issue_count;
    logic        gt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    // Model of the downstream unsigned comparator.
    assign gt = (out_a > out_b);

    cmp_issue #(.WIDTH(32)) dut (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_signed   (in_signed),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_a       (out_a),
        .out_b       (out_b),
        .issue_count (issue_count)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_signed = 1'b0; out_ready = 1'b0;
        #1;
        do_reset();
        step();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_a", out_a, 32'd0);
        check("rst_out_b", out_b, 32'd0);
        check("rst_issue_count", issue_count, 32'd0);

        // Signed pair -1 vs 1
        in_valid = 1'b1; in_a = 32'hFFFF_FFFF; in_b = 32'h0000_0001; in_signed = 1'b1;
        step();
        in_valid = 1'b0;
        check("sgn_out_valid", 32'(out_valid), 32'd1);
        check("sgn_out_a", out_a, 32'h7FFF_FFFF);
        check("sgn_out_b", out_b, 32'h8000_0001);
        check("sgn_gt", 32'(gt), 32'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("sgn_pop_count", issue_count, 32'd1);
        check("sgn_pop_empty", 32'(out_valid), 32'd0);

        // Same pair, unsigned
        in_valid = 1'b1; in_signed = 1'b0;
        step();
        in_valid = 1'b0;
        check("uns_out_a", out_a, 32'hFFFF_FFFF);
        check("uns_out_b", out_b, 32'h0000_0001);
        check("uns_gt", 32'(gt), 32'd1);

        // Reset while a pair is buffered
        in_valid = 1'b1; in_a = 32'h55; in_b = 32'h66;
        step();
        in_valid = 1'b0;
        check("mid_pre_reset_ready", 32'(in_ready), 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_out_a", out_a, 32'd0);
        check("mid_rst_issue_count", issue_count, 32'd0);

        // Backpressure: third pair must be refused
        in_valid = 1'b1; in_a = 32'h11; in_b = 32'h12;
        step();
        in_a = 32'h21; in_b = 32'h22;
        check("bp_ready_after_1", 32'(in_ready), 32'd1);
        step();
        check("bp_ready_after_2", 32'(in_ready), 32'd0);
        in_a = 32'h31; in_b = 32'h32;
        step();
        check("bp_ready_held", 32'(in_ready), 32'd0);
        check("bp_head_stable", out_a, 32'h11);
        in_valid = 1'b0; out_ready = 1'b1;
        check("bp_first_a", out_a, 32'h11);
        check("bp_first_b", out_b, 32'h12);
        step();
        check("bp_second_a", out_a, 32'h21);
        check("bp_second_b", out_b, 32'h22);
        step();
        check("bp_drained", 32'(out_valid), 32'd0);
        check("bp_issue_count", issue_count, 32'd2);

        // Streaming 100 pairs with out_ready held high
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1; in_a = 32'(i + 1000); in_b = 32'(i);
            step();
            check("stream_valid", 32'(out_valid), 32'd1);
            check("stream_a", out_a, 32'(i + 1000));
            check("stream_ready", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        step();
        check("stream_empty", 32'(out_valid), 32'd0);
        check("stream_issue_count", issue_count, 32'd100);

        // Flush at count 2 with out_ready high and a pair offered
        out_ready = 1'b0; in_valid = 1'b1; in_a = 32'hA1; in_b = 32'hA2;
        step();
        in_a = 32'hB1; in_b = 32'hB2;
        step();
        flush = 1'b1; out_ready = 1'b1; in_a = 32'hC1; in_b = 32'hC2;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("fl2_out_valid", 32'(out_valid), 32'd0);
        check("fl2_in_ready", 32'(in_ready), 32'd1);
        check("fl2_issue_count", issue_count, 32'd100);

        // Flush at count 1 with a real push and pop in the same cycle
        out_ready = 1'b0; in_valid = 1'b1; in_a = 32'hD1;
        step();
        flush = 1'b1; out_ready = 1'b1; in_a = 32'hE1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("fl1_out_valid", 32'(out_valid), 32'd0);
        check("fl1_issue_count", issue_count, 32'd100);
        step();
        check("fl1_no_ghost", 32'(out_valid), 32'd0);

        // Counter wrap
        force dut.issue_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.issue_cnt;
        out_ready = 1'b0; in_valid = 1'b1; in_a = 32'h1; in_b = 32'h2;
        step();
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("wrap_issue_count", issue_count, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
